// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader: processor mode encoding and
// loader FSM states.
package prog_loader_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RUN        = 2'b00,
    LOAD_INSTR = 2'b01,
    LOAD_REG   = 2'b10,
    HOLD       = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

endpackage

// File: rtl/prog_loader_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a registered
// one-cycle pulse on every synchronised rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic sync_q1_r;
  logic sync_q2_r;
  logic rise_r;

  // Synchronise the level and flag the cycle where q1 has risen but q2 has not.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1_r <= 1'b0;
      sync_q2_r <= 1'b0;
      rise_r    <= 1'b0;
    end else begin
      sync_q1_r <= level;
      sync_q2_r <= sync_q1_r;
      rise_r    <= sync_q1_r & ~sync_q2_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/prog_loader.sv
// Boot-time sequencer: streams instruction words, then register words, from a
// synchronous ROM into the processor's serial programming port, then releases it to run.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int N_INSTR = 32,
  parameter int N_REGS  = 16,
  parameter int WORD_W  = 8,
  parameter int TIMEOUT = 4096,
  parameter int AW      = $clog2(N_INSTR + N_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AW-1:0]     rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic              sclk_in,
  input  logic              done_in,
  output logic [MODE_W-1:0] mode_out,
  output logic              mosi_out,
  output logic              busy,
  output logic              loaded,
  output logic              error
);

  localparam int TOTAL = N_INSTR + N_REGS;
  localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW-1:0] LAST_IDX  = AW'(TOTAL - 1);
  localparam logic [AW-1:0] LAST_INSTR = AW'(N_INSTR - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  state_e            state_r;
  mode_e             mode_r;
  logic              mosi_r;
  logic              busy_r;
  logic              loaded_r;
  logic              error_r;
  logic [AW-1:0]     idx_r;
  logic [WORD_W-2:0] shift_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [TW-1:0]     tmo_r;

  logic sclk_rise_s;
  logic done_rise_s;
  logic timeout_s;

  sync_edge u_sclk_edge (
    .clk   (clk),
    .rst   (rst),
    .level (sclk_in),
    .rise  (sclk_rise_s)
  );

  sync_edge u_done_edge (
    .clk   (clk),
    .rst   (rst),
    .level (done_in),
    .rise  (done_rise_s)
  );

  // A wait expires only when the counter is spent and this cycle brings no progress.
  always_comb begin
    timeout_s = 1'b0;
    if (state_r == ST_SHIFT) begin
      timeout_s = !sclk_rise_s && (tmo_r == TMO_LAST);
    end else if (state_r == ST_WAIT_DONE) begin
      timeout_s = !done_rise_s && (tmo_r == TMO_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Loader sequencer; the word index doubles as the ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mode_r    <= HOLD;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      loaded_r  <= 1'b0;
      error_r   <= 1'b0;
      idx_r     <= '0;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      tmo_r     <= '0;
    end else if (timeout_s) begin
      state_r <= ST_ERR;
      error_r <= 1'b1;
      busy_r  <= 1'b0;
      mode_r  <= HOLD;
      mosi_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (start) begin
            loaded_r <= 1'b0;
            error_r  <= 1'b0;
            idx_r    <= '0;
            busy_r   <= 1'b1;
            mode_r   <= LOAD_INSTR;
            mosi_r   <= 1'b0;
            state_r  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          // MSB goes out now so it is stable before the processor's first edge.
          shift_r   <= rom_data[WORD_W-2:0];
          mosi_r    <= rom_data[WORD_W-1];
          bit_cnt_r <= '0;
          tmo_r     <= '0;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise_s) begin
            tmo_r <= '0;
            if (bit_cnt_r == LAST_BIT) begin
              mosi_r  <= 1'b0;
              state_r <= ST_WAIT_DONE;
            end else begin
              bit_cnt_r <= bit_cnt_r + BW'(1);
              mosi_r    <= shift_r[WORD_W-2];
              shift_r   <= shift_r << 1;
            end
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (done_rise_s) begin
            tmo_r <= '0;
            if (idx_r == LAST_IDX) begin
              mode_r   <= RUN;
              busy_r   <= 1'b0;
              loaded_r <= 1'b1;
              state_r  <= ST_RUN;
            end else begin
              if (idx_r == LAST_INSTR) begin
                mode_r <= LOAD_REG;
              end
              idx_r   <= idx_r + AW'(1);
              state_r <= ST_FETCH;
            end
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mode_r  <= HOLD;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = idx_r;
  assign mode_out = mode_r;
  assign mosi_out = mosi_r;
  assign busy     = busy_r;
  assign loaded   = loaded_r;
  assign error    = error_r;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time sequencer that loads the tiny processor's instruction memory, then its register file, over the processor's serial programming pins. Mode lines and MOSI come from this block; the bit clock and word-done strobe come from the processor.
- Word images come from a synchronous ROM (1-cycle read latency) addressed by this block.
- When loading completes, the block switches the processor to run mode and stays idle until the next start.
- Sits in the FPGA demo top level between the switch/button inputs and the processor's uio pins.

Parameters:
- N_INSTR, 32, instruction words to load
- N_REGS, 16, register words to load
- WORD_W, 8, bits per word, shifted MSB first
- TIMEOUT, 4096, clk cycles allowed per wait (sclk edge or done) before error
- AW, $clog2(N_INSTR+N_REGS), ROM address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load when idle, run or error
- rom_addr  out  AW  ROM read address: instructions at 0..N_INSTR-1, registers at N_INSTR..N_INSTR+N_REGS-1
- rom_data  in  WORD_W  ROM data, valid 1 cycle after rom_addr
- sclk_in  in  1  processor bit clock (asynchronous to clk)
- done_in  in  1  processor word-accepted flag (asynchronous)
- mode_out  out  2  processor mode: 00 RUN, 01 LOAD_INSTR, 10 LOAD_REG, 11 HOLD
- mosi_out  out  1  serial data to processor
- busy  out  1  high while loading
- loaded  out  1  high after a successful load, cleared by start
- error  out  1  high after a timeout, cleared by start

Behaviour:
- Reset values: mode_out=11 (HOLD), mosi_out=0, rom_addr=0, busy=0, loaded=0, error=0, FSM=IDLE.
- Synchronisers: sclk_in and done_in each pass through a 2-flop synchroniser.
  - A rising edge is sync_q1 & ~sync_q2, registered. Detection latency is 3 clk cycles.
- States: IDLE, FETCH, LATCH, SHIFT, WAIT_DONE, RUN, ERR.
- IDLE/RUN/ERR + start:
  - Clear loaded and error, set word index=0, busy=1.
  - Drive mode_out=01, go to FETCH.
- FETCH (1 cycle): rom_addr=index, then go to LATCH.
- LATCH (1 cycle):
  - Shift register <= rom_data, bit count=0.
  - mosi_out <= rom_data[WORD_W-1], so the bit is presented before the first edge.
  - Go to SHIFT.
- SHIFT:
  - On each detected sclk rising edge, increment the bit count. If count < WORD_W-1, shift left and set mosi_out to the next bit.
  - On the WORD_W-th edge, set mosi_out=0 and go to WAIT_DONE.
- WAIT_DONE:
  - On a done rising edge, increment the index.
  - If index is now N_INSTR: mode_out=10 (registers follow the same FETCH path).
  - If index is now N_INSTR+N_REGS: mode_out=00, busy=0, loaded=1, go to RUN.
  - Otherwise go to FETCH.
  - Done edges seen in any other state are ignored.
- Timeout counter:
  - Resets on entry to SHIFT and WAIT_DONE, and on every detected sclk edge.
  - At TIMEOUT cycles without progress: go to ERR with error=1, busy=0, mode_out=11, mosi_out=0.
- start while busy: ignored, with no restart and no state change.
- start and rst in the same cycle: rst wins.
- rst mid-load: immediate return to reset values; a partial load is abandoned.
- Extra sclk edges after the last bit are ignored until the next LATCH.
- Index and address counters never exceed N_INSTR+N_REGS-1.
- Per-word overhead between done and the next first bit: 2 cycles (FETCH, LATCH) plus 3 cycles synchroniser latency.

Decomposition:
- Package prog_loader_pkg holds:
  - typedef enum mode_e {RUN, LOAD_INSTR, LOAD_REG, HOLD}
  - the FSM state enum
  - MODE_W=2
- One sub-module, sync_edge: 2-flop synchroniser plus registered rising-edge detector. It is instantiated twice (sclk_in, done_in).

Test Plan:
- Full load (N_INSTR=4, N_REGS=2, ROM[i]=8'hA0+i), processor model clocking sclk every 8 clk and pulsing done after each word:
  - Captured words are A0..A5 in order.
  - mode_out is 01 for words 0-3 and 10 for words 4-5, then 00.
  - loaded=1 and busy=0 at the end.
- Bit order: ROM[0]=8'h81. The first and last captured bits are 1, bits 1-6 are 0, and mosi_out=0 in WAIT_DONE.
- Timeout (TIMEOUT=64): stop sclk after 3 bits of word 1.
  - error=1 and mode_out=11 within 64+3 cycles of the last edge.
  - A subsequent start restarts from address 0 and clears error.
- rst asserted in SHIFT of word 2: next cycle mode_out=11, busy=0, rom_addr=0. Done and sclk edges are then ignored until start.
- start pulsed during a load: no effect on index or mode, and the load completes normally.
- A 10-cycle-wide done_in pulse counts as one word; no words are skipped.
